compressor_tree_pipe: RTL
=========================

Name: compressor_tree_pipe

Overview:
Parametrised, pipelined carry-save reduction tree. It sums NUM_IN operands of IN_SIZE bits into a redundant sum/carry pair, or optionally into a single resolved result. It is the generalised successor of the fixed 24-input combinational compressors: operand count, pipelining, signedness and final addition are all configurable. It sits between the multiplier partial-product arrays and the accumulator, with valid/ready flow control on both sides.

Parameters:
- IN_SIZE, 12, width of each input operand.
- NUM_IN, 24, number of input operands; legal range 2..64.
- OUT_SIZE, 20, width of the outputs; all arithmetic is modulo 2^OUT_SIZE; must be >= IN_SIZE.
- FINAL_ADD, 0, when 1, a carry-propagate adder stage follows the tree: sum_o holds the full sum and carry_o is 0.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- in_valid_i  in  1  input operand vector valid
- in_ready_o  out  1  block accepts the vector this cycle
- in_i  in  IN_SIZE x [0:NUM_IN-1]  operands
- signed_i  in  1  1 = sign-extend operands, 0 = zero-extend; sampled with the vector
- out_valid_o  out  1  result valid
- out_ready_i  in  1  downstream accepts the result
- sum_o  out  OUT_SIZE  sum word, or the full result when FINAL_ADD=1
- carry_o  out  OUT_SIZE  carry word, or 0 when FINAL_ADD=1

Behaviour:
- Reset: asynchronous, active-low. All stage valid bits, out_valid_o, sum_o and carry_o go to 0. in_ready_o reads 1 while out_valid_o=0. Reset mid-stream discards every in-flight vector; no partial result is emitted.
- Operand extension at the input: each operand is extended to the working width according to signed_i (sign- or zero-extension).
- Tree construction, per level:
  - Operands are taken in groups of 4; each group feeds one 4:2 compressor and produces 2 words.
  - A remainder of 3 is zero-padded to 4 and compressed the same way.
  - A remainder of 1 or 2 passes through unchanged.
  - Levels repeat until 2 words remain.
  - LEVELS = number of such levels (NUM_IN=24 -> 4; NUM_IN=5 -> 2). NUM_IN=2 -> LEVELS=1, a pure register stage.
- One register stage follows every level; a further register stage follows the adder when FINAL_ADD=1.
- Latency: LATENCY = LEVELS + FINAL_ADD cycles from input handshake to out_valid_o, assuming no stall.
- Width rule: internal words may be narrower than OUT_SIZE where safe, but the required invariant is (sum_o + carry_o) mod 2^OUT_SIZE = sum of the extended operands mod 2^OUT_SIZE. Overflow wraps silently.
- Flow control: global stall.
  - advance = out_ready_i | ~out_valid_o; in_ready_o = advance (combinational).
  - When advance=1, every stage register and its valid bit load from the previous stage; stage 0 valid loads in_valid_i.
  - When advance=0, all stages hold. Internal bubbles are not collapsed.
  - Data registers may load when their valid bit is 0, but outputs are 0 whenever out_valid_o=0.
- Simultaneous accept at input and output in the same cycle is legal; full throughput is 1 vector per cycle.
- The output is held stable while out_valid_o=1 and out_ready_i=0.
- Ordering: results leave in acceptance order. No vector is dropped or duplicated.
- Assertions: NUM_IN within range and OUT_SIZE >= IN_SIZE, checked at elaboration.

Test Plan:
- Defaults, signed_i=1, all 24 inputs = 12'h001, out_ready_i=1 -> out_valid_o exactly 4 cycles later; sum_o+carry_o = 20'd24.
- Defaults, all inputs = 12'hFFF: signed_i=1 -> sum = 20'hFFFE8 (-24); next vector with signed_i=0 -> sum = 20'h17FE8 (98280). Back-to-back, on consecutive cycles.
- Stream 6 distinct vectors, out_ready_i low for cycles 5-7 -> in_ready_o low in those cycles; outputs held stable; all 6 results appear in order with no loss or duplicates.
- FINAL_ADD=1, 1000 random vectors with random signed_i and random out_ready_i -> carry_o always 0; sum_o matches the reference model; latency is 5.
- Assert rst_ni low for 1 cycle while 3 vectors are in flight -> out_valid_o=0 immediately; none of the 3 results ever emitted; the next accepted vector completes normally.
- NUM_IN=5, IN_SIZE=8, OUT_SIZE=12, signed inputs {127,-128,1,-1,5} -> latency 2; sum = 12'h004.

Source files
------------

// File: rtl/compressor_tree_pipe.sv
// Pipelined carry-save reduction tree: NUM_IN operands reduced through 4:2 compressor
// levels to a sum/carry pair, with an optional carry-propagate adder as the last stage.
module compressor_tree_pipe #(
    parameter int IN_SIZE   = 12,
    parameter int NUM_IN    = 24,
    parameter int OUT_SIZE  = 20,
    parameter int FINAL_ADD = 0
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                in_valid_i,
    output logic                in_ready_o,
    input  logic [IN_SIZE-1:0]  in_i [0:NUM_IN-1],
    input  logic                signed_i,
    output logic                out_valid_o,
    input  logic                out_ready_i,
    output logic [OUT_SIZE-1:0] sum_o,
    output logic [OUT_SIZE-1:0] carry_o
);

    function automatic int next_cnt(input int n);
        return ((n % 4) == 3) ? 2 * (n / 4) + 2 : 2 * (n / 4) + (n % 4);
    endfunction

    function automatic int cnt_at(input int lvl);
        int n;
        n = NUM_IN;
        for (int i = 0; i < lvl; i++) n = next_cnt(n);
        return n;
    endfunction

    // NUM_IN=2 still gets one (pass-through) level so the latency rule stays uniform.
    function automatic int num_levels();
        int n;
        int l;
        n = next_cnt(NUM_IN);
        l = 1;
        for (int i = 0; i < 16; i++) begin
            if (n > 2) begin
                n = next_cnt(n);
                l = l + 1;
            end
        end
        return l;
    endfunction

    // Two chained 3:2 counters; carries are shifted in-width so everything wraps mod 2^OUT_SIZE.
    function automatic logic [2*OUT_SIZE-1:0] comp42(
        input logic [OUT_SIZE-1:0] a,
        input logic [OUT_SIZE-1:0] b,
        input logic [OUT_SIZE-1:0] c,
        input logic [OUT_SIZE-1:0] d
    );
        logic [OUT_SIZE-1:0] s1;
        logic [OUT_SIZE-1:0] m1;
        logic [OUT_SIZE-1:0] c1;
        logic [OUT_SIZE-1:0] s2;
        logic [OUT_SIZE-1:0] m2;
        logic [OUT_SIZE-1:0] c2;
        s1 = a ^ b ^ c;
        m1 = (a & b) | (a & c) | (b & c);
        c1 = {m1[OUT_SIZE-2:0], 1'b0};
        s2 = s1 ^ c1 ^ d;
        m2 = (s1 & c1) | (s1 & d) | (c1 & d);
        c2 = {m2[OUT_SIZE-2:0], 1'b0};
        return {c2, s2};
    endfunction

    localparam int LEVELS = num_levels();

    if (NUM_IN < 2 || NUM_IN > 64) begin : g_bad_num_in
        $error("compressor_tree_pipe: NUM_IN must lie in 2..64");
    end
    if (OUT_SIZE < IN_SIZE) begin : g_bad_out_size
        $error("compressor_tree_pipe: OUT_SIZE must be >= IN_SIZE");
    end

    logic                             advance_s;
    logic [NUM_IN-1:0][OUT_SIZE-1:0]  ext_s;

    assign advance_s  = out_ready_i | ~out_valid_o;
    assign in_ready_o = advance_s;

    // Extend every operand to the working width according to the per-vector signed flag.
    always_comb begin
        ext_s = '0;
        for (int i = 0; i < NUM_IN; i++) begin
            if (signed_i) begin
                ext_s[i] = OUT_SIZE'($signed(in_i[i]));
            end else begin
                ext_s[i] = OUT_SIZE'(in_i[i]);
            end
        end
    end

    for (genvar l = 0; l < LEVELS; l++) begin : g_lvl
        localparam int NI = cnt_at(l);
        localparam int NO = cnt_at(l + 1);
        localparam int NG = NI / 4;
        localparam int NR = NI % 4;

        logic [NI-1:0][OUT_SIZE-1:0] a_s;
        logic [NO-1:0][OUT_SIZE-1:0] y_s;
        logic [NO-1:0][OUT_SIZE-1:0] y_d;
        logic [NO-1:0][OUT_SIZE-1:0] y_q;
        logic                        v_in_s;
        logic                        v_q;

        if (l == 0) begin : g_first
            assign a_s    = ext_s;
            assign v_in_s = in_valid_i;
        end else begin : g_next
            assign a_s    = g_lvl[l-1].y_q;
            assign v_in_s = g_lvl[l-1].v_q;
        end

        for (genvar g = 0; g < NG; g++) begin : g_c42
            assign {y_s[2*g+1], y_s[2*g]} =
                comp42(a_s[4*g], a_s[4*g+1], a_s[4*g+2], a_s[4*g+3]);
        end

        // A leftover of three is padded with a zero word; one or two words ride through.
        if (NR == 3) begin : g_rem3
            assign {y_s[2*NG+1], y_s[2*NG]} =
                comp42(a_s[4*NG], a_s[4*NG+1], a_s[4*NG+2], {OUT_SIZE{1'b0}});
        end else if (NR == 2) begin : g_rem2
            assign y_s[2*NG+1] = a_s[4*NG+1];
            assign y_s[2*NG]   = a_s[4*NG];
        end else if (NR == 1) begin : g_rem1
            assign y_s[2*NG] = a_s[4*NG];
        end

        assign y_d = v_in_s ? y_s : '0;

        // Level register: all stages move together on advance and hold on a stall.
        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                v_q <= 1'b0;
                y_q <= '0;
            end else if (advance_s) begin
                v_q <= v_in_s;
                y_q <= y_d;
            end
        end
    end

    if (FINAL_ADD != 0) begin : g_final_add
        logic [OUT_SIZE-1:0] fa_d;
        logic [OUT_SIZE-1:0] fa_q;
        logic                fv_q;

        assign fa_d = g_lvl[LEVELS-1].v_q ?
                      (g_lvl[LEVELS-1].y_q[0] + g_lvl[LEVELS-1].y_q[1]) : {OUT_SIZE{1'b0}};

        // Resolved-sum register behind the carry-propagate adder.
        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                fv_q <= 1'b0;
                fa_q <= '0;
            end else if (advance_s) begin
                fv_q <= g_lvl[LEVELS-1].v_q;
                fa_q <= fa_d;
            end
        end

        assign out_valid_o = fv_q;
        assign sum_o       = fa_q;
        assign carry_o     = {OUT_SIZE{1'b0}};
    end else begin : g_redundant
        assign out_valid_o = g_lvl[LEVELS-1].v_q;
        assign sum_o       = g_lvl[LEVELS-1].y_q[0];
        assign carry_o     = g_lvl[LEVELS-1].y_q[1];
    end

endmodule
